uart_tx_ctrl: RTL and testbench

//   UART transmit controller behind the 0x1000_0000 store decoder. It accepts bytes
//   on a valid/ready handshake and buffers them in a FIFO. It then serializes each

---
 rtl/uart_tx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO on a valid/ready handshake feeding an
// 8N1 serializer. Define UART_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic [7:0]                    i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
`ifdef UART_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic push;
  logic pop;
  logic baud_last;

  assign o_ready      = (count_q != CntFull);
  assign o_busy       = (state_q != StIdle) || (count_q != '0);
  assign o_fifo_count = count_q;
  assign o_tx         = tx_q;

  assign push      = i_valid && o_ready;
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign baud_last = (baud_q == BaudLast);

  // FIFO storage; data needs no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer FSM; tx_d is the line level for the cycle after this edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
`ifdef UART_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d   = StData;
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (baud_last) begin
          state_d = StIdle;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset drives the line high at once and discards queued bytes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
`ifdef UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_uart_tx_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned Depth = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned Fb = 11;
`else
  localparam int unsigned Fb = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  uart_tx_ctrl #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_data       (data),
    .o_ready      (ready),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic rx_frame(input int budget, output logic found, output int start_cyc,
                          output logic [10:0] bits, output logic stable,
                          output logic busy_last);
    logic v;
    found     = 1'b0;
    start_cyc = 0;
    bits      = '1;
    stable    = 1'b1;
    busy_last = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found     = 1'b1;
        start_cyc = cyc;
      end
    end
    if (!found) return;
    for (int b = 0; b < int'(Fb); b++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!(b == 0 && j == 0)) @(negedge clk);
        v = tx;
        if (j == 0) bits[b] = v;
        else if (v !== bits[b]) stable = 1'b0;
      end
    end
    busy_last = busy;
  endtask

  logic        f1, f2, st1, st2, bl1, bl2;
  int          s1, s2, push_cyc;
  logic [10:0] b1, b2, exp_bits;
  int          idx, stall;
  logic        low_seen;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

    // 1: reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t1_rst_tx", tx, 1);
      check_eq("t1_rst_ready", ready, 1);
      check_eq("t1_rst_busy", busy, 0);
      check_eq("t1_rst_count", fifo_count, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t1_post_tx", tx, 1);
    check_eq("t1_post_ready", ready, 1);
    check_eq("t1_post_busy", busy, 0);
    check_eq("t1_post_count", fifo_count, 0);

    // 2: single byte 0xA5
    valid    = 1'b1;
    data     = 8'hA5;
    push_cyc = cyc;
    @(negedge clk);
    valid = 1'b0;
    rx_frame(20, f1, s1, b1, st1, bl1);
    check_eq("t2_found", f1, 1);
    check_eq("t2_latency", s1 - push_cyc, 2);
`ifdef UART_PARITY_EN
    exp_bits = 11'b1_0_10100101_0;
`else
    exp_bits = 11'b1_1101001010;
`endif
    for (int b = 0; b < int'(Fb); b++) begin
      check_eq($sformatf("t2_bit%0d", b), b1[b], exp_bits[b]);
    end
    check_eq("t2_bit_width", st1, 1);
    check_eq("t2_busy_in_stop", bl1, 1);
    @(negedge clk);
    check_eq("t2_busy_after", busy, 0);
    check_eq("t2_tx_idle", tx, 1);

    // 3: back-to-back
    repeat (3) @(negedge clk);
    fork
      begin
        valid = 1'b1;
        data  = 8'h55;
        @(negedge clk);
        data = 8'h0F;
        @(negedge clk);
        valid = 1'b0;
      end
      begin
        rx_frame(20, f1, s1, b1, st1, bl1);
        rx_frame(20, f2, s2, b2, st2, bl2);
      end
    join
    check_eq("t3_found1", f1, 1);
    check_eq("t3_found2", f2, 1);
    check_eq("t3_byte1", b1[8:1], 8'h55);
    check_eq("t3_byte2", b2[8:1], 8'h0F);
    check_eq("t3_spacing", s2 - s1, Fb * N + 1);
    check_eq("t3_stable", st1 & st2, 1);

    // 4: full and stall
    repeat (3) @(negedge clk);
    fork
      begin
        idx   = 1;
        stall = 0;
        for (int t = 0; t < 200 && idx <= 6; t++) begin
          valid = 1'b1;
          data  = 8'(idx);
          if (ready) begin
            idx++;
          end else begin
            if (stall == 0) check_eq("t4_full_count", fifo_count, Depth);
            stall++;
          end
          @(negedge clk);
        end
        valid = 1'b0;
        check_eq("t4_all_pushed", idx, 7);
        check_eq("t4_stall_cycles", stall, Fb * N - 2);
      end
      begin
        for (int k = 1; k <= 6; k++) begin
          rx_frame(100, f1, s1, b1, st1, bl1);
          check_eq($sformatf("t4_found%0d", k), f1, 1);
          check_eq($sformatf("t4_byte%0d", k), b1[8:1], k);
        end
      end
    join
    @(negedge clk);
    check_eq("t4_busy_after", busy, 0);
    check_eq("t4_count_after", fifo_count, 0);

    // 5: reset mid-frame, 0x3C on the line with two bytes queued
    repeat (3) @(negedge clk);
    valid = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    data = 8'h11;
    @(negedge clk);
    data = 8'h22;
    check_eq("t5_start", tx, 0);
    @(negedge clk);
    valid = 1'b0;
    repeat (16) @(negedge clk);   // second cycle of data bit 3
    check_eq("t5_queued", fifo_count, 2);
    check_eq("t5_busy_pre", busy, 1);
    check_eq("t5_bit3", tx, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx, 1);
    check_eq("t5_rst_count", fifo_count, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_ready", ready, 1);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check_eq("t5_no_frames", low_seen, 0);
    check_eq("t5_busy_after", busy, 0);

`ifdef UART_PARITY_EN
    // 6: parity on 0x07
    valid = 1'b1;
    data  = 8'h07;
    @(negedge clk);
    valid = 1'b0;
    rx_frame(20, f1, s1, b1, st1, bl1);
    check_eq("t6_found", f1, 1);
    check_eq("t6_byte", b1[8:1], 8'h07);
    check_eq("t6_parity", b1[9], 1);
    check_eq("t6_stop", b1[10], 1);
    check_eq("t6_stable", st1, 1);
    check_eq("t6_busy_in_stop", bl1, 1);
    @(negedge clk);
    check_eq("t6_busy_after", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
